uart_tx_param: RTL

Parametrised UART transmitter with an integrated baud divider and a valid/ready byte interface. It replaces the fixed 8N1 transmitter, its free-running baud strobe and its "start pulse" interface. It generalises data width, parity and stop bits, and supports gap-free back-to-back frames. It sits between any byte producer (debug logger, command responder) and the board TX pin.

---
 rtl/uart_tx_param.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an integrated, frame-aligned baud divider.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO in front of the frame sequencer.
module uart_tx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_param: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Only the transmitted data bits take part in the parity
    function automatic logic frame_parity(input logic [7:0] data);
        logic [7:0] bits;
        bits = data & DATA_MASK;
        return (PARITY == 1) ? ~(^bits) : (^bits);
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             par_r;
    logic             txd_r;
    logic             fsm_ready_r;
    logic             fsm_busy_r;
    logic             start_s;
    logic [7:0]       start_data_s;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int PTR_BITS = PTR_W + 1;
    localparam logic [PTR_W:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [PTR_W:0] PTR_ZERO = PTR_BITS'(0);

    logic [7:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic           fifo_empty_s;
    logic           fifo_full_s;
    logic           push_s;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign push_s       = tx_valid && !fifo_full_s;
    assign start_s      = fsm_ready_r && !fifo_empty_s;
    assign start_data_s = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign tx_ready     = !fifo_full_s;
    assign tx_busy      = fsm_busy_r || !fifo_empty_s;

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (start_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage, written on every accepted byte
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= tx_data;
        end
    end
`else
    assign start_s      = tx_valid && fsm_ready_r;
    assign start_data_s = tx_data;
    assign tx_ready     = fsm_ready_r;
    assign tx_busy      = fsm_busy_r;
`endif

    assign txd = txd_r;

    // Frame sequencer: one line bit every DIV clocks, counter phase-aligned to each frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'd0;
            par_r       <= 1'b0;
            txd_r       <= 1'b1;
            fsm_ready_r <= 1'b1;
            fsm_busy_r  <= 1'b0;
        end else if (start_s) begin
            // Taken from IDLE or from the last stop clock, giving gap-free frames
            state_r     <= S_START;
            cnt_r       <= CNT_LOAD;
            idx_r       <= 3'd0;
            shift_r     <= start_data_s & DATA_MASK;
            par_r       <= frame_parity(start_data_s);
            txd_r       <= 1'b0;
            fsm_ready_r <= 1'b0;
            fsm_busy_r  <= 1'b1;
        end else if (state_r == S_IDLE) begin
            cnt_r       <= CNT_ZERO;
            txd_r       <= 1'b1;
            fsm_ready_r <= 1'b1;
            fsm_busy_r  <= 1'b0;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (state_r == S_STOP && idx_r == LAST_STOP && cnt_r == CNT_ONE) begin
                fsm_ready_r <= 1'b1;
            end
        end else begin
            cnt_r <= CNT_LOAD;
            case (state_r)
                S_START: begin
                    state_r <= S_DATA;
                    idx_r   <= 3'd0;
                    txd_r   <= shift_r[0];
                    shift_r <= {1'b0, shift_r[7:1]};
                end
                S_DATA: begin
                    if (idx_r != LAST_DATA) begin
                        idx_r   <= idx_r + 3'd1;
                        txd_r   <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                    end else if (PARITY != 0) begin
                        state_r <= S_PARITY;
                        txd_r   <= par_r;
                    end else begin
                        state_r <= S_STOP;
                        idx_r   <= 3'd0;
                        txd_r   <= 1'b1;
                    end
                end
                S_PARITY: begin
                    state_r <= S_STOP;
                    idx_r   <= 3'd0;
                    txd_r   <= 1'b1;
                end
                S_STOP: begin
                    if (idx_r != LAST_STOP) begin
                        idx_r <= idx_r + 3'd1;
                        txd_r <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                        cnt_r       <= CNT_ZERO;
                        txd_r       <= 1'b1;
                        fsm_ready_r <= 1'b1;
                        fsm_busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cnt_r       <= CNT_ZERO;
                    txd_r       <= 1'b1;
                    fsm_ready_r <= 1'b1;
                    fsm_busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
